// File: rtl/fault_injector_pkg.sv
// Shared types and constants for the multi-channel fault injector:
// FSM states, fault modes, LFSR geometry and the default LFSR seed.
package fault_injector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_INJECT = 2'd2
    } fi_state_t;

    typedef enum logic [1:0] {
        FI_FLIP   = 2'b00,
        FI_STUCK0 = 2'b01,
        FI_STUCK1 = 2'b10
    } fi_mode_t;

    // 16-bit Fibonacci LFSR, taps at stages 16,14,13,11 (bits 15,13,12,10)
    localparam int              LFSR_W       = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1;

    // Encoding 11 has no dedicated behaviour and falls back to bit-flip
    function automatic fi_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return FI_STUCK0;
            2'b10:   return FI_STUCK1;
            default: return FI_FLIP;
        endcase
    endfunction

endpackage

// File: rtl/fi_lfsr.sv
// 16-bit Fibonacci LFSR used to pick random fault targets.
// Only instantiated when FI_RANDOM_EN is defined.
module fi_lfsr
    import fault_injector_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] lfsr_q;

    // Shift left, feeding the XOR of the tapped stages into bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/fault_injector_mc.sv
// Multi-channel fault injector. Periodically forces one bit of data_i
// (bit-flip, stuck-at-0 or stuck-at-1) for a programmable duration.
// Target selection is round-robin by default; defining FI_RANDOM_EN
// switches to LFSR-driven pseudo-random targets.
module fault_injector_mc
    import fault_injector_pkg::*;
#(
    parameter int                N    = 8,
    parameter int                CW   = 8,
    parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [1:0]    mode_i,
    input  logic [CW-1:0] interval_i,
    input  logic [CW-1:0] duration_i,
    input  logic [N-1:0]  data_i,
    output logic [N-1:0]  data_o,
    output logic [N-1:0]  fi_out_o,
    output logic          busy_o,
    output logic [15:0]   inj_cnt_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    fi_state_t      state;
    fi_state_t      state_nxt;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   mask;
    fi_mode_t       mode_q;
    logic [15:0]    inj_cnt;
    logic [IW-1:0]  target;
    logic [CW-1:0]  dur_m1;

    logic           load_wait;
    logic           start_inject;
    logic           finish;
    logic           cnt_dec;

    function automatic logic [N-1:0] apply_fault(input fi_mode_t m,
                                                 input logic [N-1:0] d,
                                                 input logic [N-1:0] msk);
        case (m)
            FI_STUCK0: return d & ~msk;
            FI_STUCK1: return d | msk;
            default:   return d ^ msk;
        endcase
    endfunction

    // A zero duration still produces a one-cycle fault
    assign dur_m1 = (duration_i == '0) ? '0 : duration_i - CW'(1);

`ifdef FI_RANDOM_EN
    logic [LFSR_W-1:0] lfsr;
    logic [IW:0]       raw_ext;

    fi_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk_i),
        .rst   (rst_i),
        .en    (1'b1),
        .state (lfsr)
    );

    // Fold out-of-range LFSR samples back into 0..N-1
    always_comb begin
        raw_ext = {1'b0, lfsr[IW-1:0]};
        target  = lfsr[IW-1:0];
        if (raw_ext >= (IW+1)'(N)) begin
            target = IW'(raw_ext - (IW+1)'(N));
        end
    end
`else
    logic [IW-1:0] ptr;

    // Round-robin pointer steps once per injection and wraps at N-1
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (start_inject) begin
            ptr <= (ptr == IW'(N - 1)) ? '0 : ptr + 1'b1;
        end
    end

    assign target = ptr;
`endif

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        state_nxt    = state;
        load_wait    = 1'b0;
        start_inject = 1'b0;
        finish       = 1'b0;
        cnt_dec      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en_i) begin
                    state_nxt = ST_WAIT;
                    load_wait = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!en_i) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == '0) begin
                    state_nxt    = ST_INJECT;
                    start_inject = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_INJECT: begin
                // en_i is ignored until the fault has run its full length
                if (cnt == '0) begin
                    finish = 1'b1;
                    if (en_i) begin
                        state_nxt = ST_WAIT;
                        load_wait = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Interval/duration counter, fault mask, latched mode and injection count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt     <= '0;
            mask    <= '0;
            mode_q  <= FI_FLIP;
            inj_cnt <= '0;
        end else begin
            if (load_wait) begin
                cnt <= interval_i;
            end else if (start_inject) begin
                cnt <= dur_m1;
            end else if (cnt_dec) begin
                cnt <= cnt - CW'(1);
            end

            if (start_inject) begin
                mask   <= {{(N-1){1'b0}}, 1'b1} << target;
                mode_q <= decode_mode(mode_i);
            end else if (finish) begin
                mask <= '0;
            end

            if (finish && (inj_cnt != 16'hFFFF)) begin
                inj_cnt <= inj_cnt + 16'd1;
            end
        end
    end

    assign data_o    = apply_fault(mode_q, data_i, mask);
    assign fi_out_o  = mask;
    assign busy_o    = (state != ST_IDLE);
    assign inj_cnt_o = inj_cnt;

endmodule
